alu_host_interface: RTL and testbench
=====================================

# alu_host_interface

Upstream front end for the ALU control unit and datapath. It accepts one operation request over a valid/ready handshake and holds the operands. It drives INBUS in step with the control unit's register-load strobes, pulses BEGIN, and captures the A/Q values the control unit pushes to OUTBUS. It then presents a single formatted result over a second valid/ready handshake.

## Interface
- WIDTH, 8, datapath/bus width; also width of A, Q and M.
- TIMEOUT, 64, watchdog limit in cycles (RUN state only). Used only when ALU_HOST_TIMEOUT_EN is defined.

- clk  in  1  system clock; all flops rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- req_a  in  WIDTH  A operand: add/sub first operand; div dividend high. Ignored for mul.
- req_q  in  WIDTH  Q operand: mul multiplier; div dividend low. Ignored for add/sub.
- req_m  in  WIDTH  M operand: second operand, multiplicand or divisor.
- cu_begin  out  1  BEGIN to the control unit.
- cu_op_code  out  2  op_code to the control unit; holds the captured opcode from START until IDLE.
- cu_loadA, cu_loadQ, cu_loadM  in  1 each  control unit INBUS load strobes.
- inbus  out  WIDTH  operand bus to the datapath.
- cu_pushA, cu_pushQ  in  1 each  control unit OUTBUS push strobes.
- outbus  in  WIDTH  datapath output bus.
- cu_end  in  1  END from the control unit.
- cu_idle  in  1  control unit IDLE state bit.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_hi, rsp_lo  out  WIDTH each  result words.
- rsp_err  out  1  error flag: divide-by-zero or timeout.

## Operation
- FSM states: IDLE, START, RUN, RESP.
- IDLE:
  - req_ready = cu_idle.
  - On accept, capture op/a/q/m and clear rsp_hi, rsp_lo and rsp_err.
  - If op = 11 and req_m = 0: set rsp_err = 1 and go to RESP. cu_begin is never asserted. This is required because the control unit's leading-zero loop never terminates when M = 0.
  - Otherwise go to START.
- START: cu_begin = 1 for exactly one cycle, then go to RUN.
- inbus is combinational:
  - cu_loadA selects the captured A.
  - else cu_loadQ selects the captured Q.
  - else cu_loadM selects the captured M.
  - else 0.
  - Load strobes are honoured only in START and RUN; inbus = 0 in all other states.
- Push capture:
  - pushA_d and pushQ_d are the push strobes registered by one cycle; OUTBUS is valid while the control unit sits in a PUSH state.
  - In RUN, pushA_d writes outbus to the A slot; pushQ_d writes outbus to the Q slot.
- Result mapping:
  - add/sub: rsp_lo = A, rsp_hi = 0.
  - mul: rsp_hi = A, rsp_lo = Q.
  - div: rsp_lo = Q (quotient), rsp_hi = A (remainder).
- RUN to RESP: on cu_end. Any capture in that same cycle (pushX_d) is still committed.
- RESP: rsp_valid = 1; outputs are stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
- Strobes arriving outside START/RUN are ignored. cu_end seen in IDLE or RESP is ignored.

## Timing
- All outputs are 0 in reset, including cu_op_code.
- Reset is asynchronous; assertion mid-operation returns the FSM to IDLE immediately and discards captured data.
- Cycle numbering for a request accepted at edge 0:
  - cu_begin is high during cycle 1.
  - rsp_valid rises on the edge after the cu_end cycle.
- Divide-by-zero: rsp_valid is high in cycle 1 with rsp_err = 1.
- Back-to-back operation: a new accept is possible in the cycle after the RESP handshake, provided cu_idle = 1.
- req_ready and rsp_valid are never high in the same cycle.

## Configuration
- ALU_HOST_TIMEOUT_EN:
  - Defined: an 8-bit-or-wider cycle counter resets on entry to RUN. If it reaches TIMEOUT before cu_end, the FSM goes to RESP with rsp_err = 1 and rsp_hi/rsp_lo as captured so far. Afterwards req_ready stays low until cu_idle = 1.
  - Not defined: no counter exists, and RUN waits indefinitely for cu_end.

## Test plan
- add: a=0x25, m=0x13 -> cu_begin pulse one cycle after accept; rsp_lo=0x38, rsp_hi=0x00, rsp_err=0.
- mul: q=0x07, m=0x06 -> rsp_hi=0x00, rsp_lo=0x2A; inbus=0x07 on cu_loadQ, 0x06 on cu_loadM.
- div: a=0x00, q=0x64, m=0x07 -> rsp_lo=0x0E, rsp_hi=0x02.
- div by zero: q=0x10, m=0x00 -> rsp_valid with rsp_err=1 in cycle 1; cu_begin stays 0 throughout.
- backpressure and reset:
  - rsp_ready held low for 10 cycles -> rsp_* stable and req_ready=0.
  - reset pulsed in RUN -> all outputs 0 the same cycle; FSM in IDLE.
- with ALU_HOST_TIMEOUT_EN and TIMEOUT=16: control unit model never asserts cu_end -> rsp_err=1 and rsp_valid at RUN cycle 16; req_ready=0 until cu_idle rises.

Source files
------------

// File: rtl/alu_host_interface.sv
// Host front end for the ALU control unit: request capture, INBUS drive, OUTBUS capture, result handshake.
// Optional RUN-state watchdog is compiled in when ALU_HOST_TIMEOUT_EN is defined.
module alu_host_interface #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_q,
  input  logic [WIDTH-1:0] req_m,
  output logic             cu_begin,
  output logic [1:0]       cu_op_code,
  input  logic             cu_loadA,
  input  logic             cu_loadQ,
  input  logic             cu_loadM,
  output logic [WIDTH-1:0] inbus,
  input  logic             cu_pushA,
  input  logic             cu_pushQ,
  input  logic [WIDTH-1:0] outbus,
  input  logic             cu_end,
  input  logic             cu_idle,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_err
);

  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_push_a_d;
  logic             r_push_q_d;
  logic             r_cu_begin;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_hi;
  logic [WIDTH-1:0] r_rsp_lo;
  logic             r_rsp_err;

  logic             w_req_ready;
  logic             w_accept;
  logic             w_div0;
  logic             w_addsub;
  logic             w_tmo_hit;
  logic             w_loads_on;
  logic [WIDTH-1:0] w_inbus;

  // Gated by reset so every output reads 0 while reset is held.
  assign w_req_ready = reset && (r_state == S_IDLE) && cu_idle;
  assign w_accept    = req_valid && w_req_ready;
  assign w_div0      = (req_op == OP_DIV) && (req_m == '0);
  assign w_addsub    = ~r_op[1];
  assign w_loads_on  = (r_state == S_START) || (r_state == S_RUN);

`ifdef ALU_HOST_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts RUN cycles; held at zero elsewhere so it restarts on every RUN entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state != S_RUN) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  assign w_tmo_hit = (r_state == S_RUN) && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  // Watchdog compiled out; RUN waits for cu_end indefinitely.
  assign w_tmo_hit = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_div0 ? S_RESP : S_START;
        end
      end
      S_START: begin
        w_next = S_RUN;
      end
      S_RUN: begin
        if (cu_end || w_tmo_hit) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, strobe delay and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op        <= '0;
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_push_a_d  <= 1'b0;
      r_push_q_d  <= 1'b0;
      r_cu_begin  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_hi    <= '0;
      r_rsp_lo    <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_push_a_d  <= cu_pushA;
      r_push_q_d  <= cu_pushQ;
      r_cu_begin  <= (w_next == S_START);
      r_rsp_valid <= (w_next == S_RESP);

      if (w_accept) begin
        r_op      <= req_op;
        r_a       <= req_a;
        r_q       <= req_q;
        r_m       <= req_m;
        r_rsp_hi  <= '0;
        r_rsp_lo  <= '0;
        r_rsp_err <= w_div0;
      end

      if (r_state == S_RUN) begin
        // add/sub return only A, in the low word; mul/div return A high, Q low.
        if (r_push_a_d) begin
          if (w_addsub) begin
            r_rsp_lo <= outbus;
          end else begin
            r_rsp_hi <= outbus;
          end
        end
        if (r_push_q_d && !w_addsub) begin
          r_rsp_lo <= outbus;
        end
        if (w_tmo_hit && !cu_end) begin
          r_rsp_err <= 1'b1;
        end
      end

      if ((r_state == S_RESP) && rsp_ready) begin
        r_op <= '0;
      end
    end
  end

  // INBUS mux: A over Q over M, live only while the control unit is running.
  always_comb begin
    w_inbus = '0;
    if (w_loads_on) begin
      if (cu_loadA) begin
        w_inbus = r_a;
      end else if (cu_loadQ) begin
        w_inbus = r_q;
      end else if (cu_loadM) begin
        w_inbus = r_m;
      end
    end
  end

  assign req_ready  = w_req_ready;
  assign inbus      = w_inbus;
  assign cu_begin   = r_cu_begin;
  assign cu_op_code = r_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_hi     = r_rsp_hi;
  assign rsp_lo     = r_rsp_lo;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_host_interface.sv
// Self-checking bench for alu_host_interface with a procedural control-unit model and arithmetic reference.
module tb_alu_host_interface;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a, req_q, req_m;
  logic         cu_begin;
  logic [1:0]   cu_op_code;
  logic         cu_loadA, cu_loadQ, cu_loadM;
  logic [W-1:0] inbus;
  logic         cu_pushA, cu_pushQ;
  logic [W-1:0] outbus;
  logic         cu_end, cu_idle;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_hi, rsp_lo;
  logic         rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_host_interface #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_q(req_q), .req_m(req_m),
    .cu_begin(cu_begin), .cu_op_code(cu_op_code),
    .cu_loadA(cu_loadA), .cu_loadQ(cu_loadQ), .cu_loadM(cu_loadM),
    .inbus(inbus), .cu_pushA(cu_pushA), .cu_pushQ(cu_pushQ),
    .outbus(outbus), .cu_end(cu_end), .cu_idle(cu_idle),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int   begin_cnt = 0;
  logic both_seen = 1'b0;
  always @(negedge clk) begin
    if (cu_begin) begin_cnt++;
    if (req_ready && rsp_valid) both_seen = 1'b1;
  end

  // Observations from the last transaction
  int           obs_wait, obs_lat, obs_begin, obs_nload;
  logic         obs_c1_begin, obs_c1_valid, obs_c1_err, obs_hang;
  logic [1:0]   obs_c1_op;
  logic [W-1:0] obs_inbus[3];
  logic [W-1:0] exp_inbus[3];
  logic [W-1:0] obs_hi, obs_lo;
  logic         obs_err, obs_stable, obs_ready_resp;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a, q, m,
                                    output logic [W-1:0] hi, output logic [W-1:0] lo,
                                    output logic err);
    logic [2*W-1:0] p;
    hi = '0; lo = '0; err = 1'b0;
    case (op)
      2'b00: lo = W'(a + m);
      2'b01: lo = W'(a - m);
      2'b10: begin p = (2*W)'(q) * (2*W)'(m); hi = p[2*W-1:W]; lo = p[W-1:0]; end
      default: begin
        if (m == '0) err = 1'b1;
        else begin
          p  = {a, q};
          lo = W'(p / (2*W)'(m));
          hi = W'(p % (2*W)'(m));
        end
      end
    endcase
  endfunction

  // Drive one request through a behavioural control unit and record what the DUT shows.
  task automatic run_txn(input logic [1:0] op, input logic [W-1:0] a, q, m, input int hold);
    logic [W-1:0] ehi, elo, pa, pq;
    logic         eerr;
    logic [1:0]   ld [3];
    int           n, b0;
    obs_hang = 1'b0; obs_nload = 0; b0 = begin_cnt;
    ref_model(op, a, q, m, ehi, elo, eerr);
    req_op = op; req_a = a; req_q = q; req_m = m; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin n++; @(negedge clk); end
    obs_wait = n;
    if (!req_ready) begin obs_hang = 1'b1; req_valid = 1'b0; return; end
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    obs_c1_begin = cu_begin; obs_c1_valid = rsp_valid;
    obs_c1_err = rsp_err; obs_c1_op = cu_op_code;
    if (!eerr) begin
      cyc();
      cu_idle = 1'b0;
      if (op[1] == 1'b0)   begin ld[0] = 2'd0; ld[1] = 2'd2; obs_nload = 2; end
      else if (op == 2'b10) begin ld[0] = 2'd1; ld[1] = 2'd2; obs_nload = 2; end
      else begin ld[0] = 2'd0; ld[1] = 2'd1; ld[2] = 2'd2; obs_nload = 3; end
      for (int i = 0; i < obs_nload; i++) begin
        cu_loadA = (ld[i] == 2'd0); cu_loadQ = (ld[i] == 2'd1); cu_loadM = (ld[i] == 2'd2);
        exp_inbus[i] = (ld[i] == 2'd0) ? a : (ld[i] == 2'd1) ? q : m;
        @(negedge clk);
        obs_inbus[i] = inbus;
        cyc();
        cu_loadA = 1'b0; cu_loadQ = 1'b0; cu_loadM = 1'b0;
      end
      repeat ($urandom_range(0, 3)) cyc();
      if (op[1] == 1'b0) begin pa = elo; pq = W'($urandom); end
      else begin pa = ehi; pq = elo; end
      cu_pushA = 1'b1; outbus = pa; cyc();
      cu_pushA = 1'b0; cyc();
      cu_pushQ = 1'b1; outbus = pq; cyc();
      // END in the same cycle the delayed Q push is captured
      cu_pushQ = 1'b0; cu_end = 1'b1; cyc();
      cu_end = 1'b0; cu_idle = 1'b1; outbus = W'($urandom);
      @(negedge clk);
    end
    n = 0;
    while (!rsp_valid && n < 50) begin n++; @(negedge clk); end
    obs_lat = n;
    if (!rsp_valid) begin obs_hang = 1'b1; return; end
    obs_hi = rsp_hi; obs_lo = rsp_lo; obs_err = rsp_err;
    obs_stable = 1'b1; obs_ready_resp = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_hi !== obs_hi || rsp_lo !== obs_lo || rsp_err !== obs_err) obs_stable = 1'b0;
      if (req_ready) obs_ready_resp = 1'b1;
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    obs_begin = begin_cnt - b0;
  endtask

  task automatic check_result(input string name, input logic [1:0] op, input logic [W-1:0] a, q, m);
    logic [W-1:0] ehi, elo;
    logic         eerr;
    ref_model(op, a, q, m, ehi, elo, eerr);
    n_tests++;
    if (obs_hang) begin
      n_fail++; $display("FAIL %s: handshake timed out", name);
    end else if ({obs_hi, obs_lo, obs_err} !== {ehi, elo, eerr}) begin
      n_fail++;
      $display("FAIL %s: op=%0d a=%h q=%h m=%h got hi=%h lo=%h err=%b want hi=%h lo=%h err=%b",
               name, op, a, q, m, obs_hi, obs_lo, obs_err, ehi, elo, eerr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cu_idle = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, cu_begin, cu_op_code, inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b beg=%b op=%b inbus=%h v=%b hi=%h lo=%h err=%b want all 0",
               req_ready, cu_begin, cu_op_code, inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", req_ready); end
    cyc();
  endtask

  task automatic test_add();
    run_txn(2'b00, 8'h25, 8'h00, 8'h13, 0);
    check_result("add", 2'b00, 8'h25, 8'h00, 8'h13);
    n_tests++;
    if (obs_c1_begin !== 1'b1 || obs_begin != 1) begin
      n_fail++; $display("FAIL add_begin: cycle1=%b pulses=%0d want 1 and 1", obs_c1_begin, obs_begin);
    end
    n_tests++;
    if (obs_inbus[0] !== 8'h25 || obs_inbus[1] !== 8'h13) begin
      n_fail++; $display("FAIL add_inbus: got %h,%h want 25,13", obs_inbus[0], obs_inbus[1]);
    end
    n_tests++;
    if (obs_lat != 0) begin n_fail++; $display("FAIL add_latency: extra cycles %0d want 0", obs_lat); end
  endtask

  task automatic test_mul();
    run_txn(2'b10, 8'h00, 8'h07, 8'h06, 0);
    check_result("mul", 2'b10, 8'h00, 8'h07, 8'h06);
    n_tests++;
    if (obs_inbus[0] !== 8'h07 || obs_inbus[1] !== 8'h06) begin
      n_fail++; $display("FAIL mul_inbus: got %h,%h want 07,06", obs_inbus[0], obs_inbus[1]);
    end
    n_tests++;
    if (obs_c1_op !== 2'b10) begin n_fail++; $display("FAIL mul_opcode: got %b want 10", obs_c1_op); end
  endtask

  task automatic test_div();
    run_txn(2'b11, 8'h00, 8'h64, 8'h07, 0);
    check_result("div", 2'b11, 8'h00, 8'h64, 8'h07);
    n_tests++;
    if (obs_hi !== 8'h02 || obs_lo !== 8'h0E) begin
      n_fail++; $display("FAIL div_value: got hi=%h lo=%h want 02 0e", obs_hi, obs_lo);
    end
  endtask

  task automatic test_div0();
    run_txn(2'b11, 8'h00, 8'h10, 8'h00, 2);
    check_result("div0", 2'b11, 8'h00, 8'h10, 8'h00);
    n_tests++;
    if (obs_c1_valid !== 1'b1 || obs_c1_err !== 1'b1) begin
      n_fail++; $display("FAIL div0_cycle1: valid=%b err=%b want 1 1", obs_c1_valid, obs_c1_err);
    end
    n_tests++;
    if (obs_begin != 0) begin n_fail++; $display("FAIL div0_begin: pulses=%0d want 0", obs_begin); end
  endtask

  task automatic test_backpressure();
    run_txn(2'b01, 8'h90, 8'h00, 8'h31, 10);
    check_result("bp_value", 2'b01, 8'h90, 8'h00, 8'h31);
    n_tests++;
    if (obs_stable !== 1'b1 || obs_ready_resp !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: stable=%b req_ready_seen=%b want 1 0", obs_stable, obs_ready_resp);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(2'b00, 8'hF0, 8'h00, 8'h20, 0);
    check_result("b2b_first", 2'b00, 8'hF0, 8'h00, 8'h20);
    run_txn(2'b10, 8'h00, 8'h13, 8'h11, 0);
    check_result("b2b_second", 2'b10, 8'h00, 8'h13, 8'h11);
    n_tests++;
    if (obs_wait != 0) begin n_fail++; $display("FAIL b2b_ready: waited %0d want 0", obs_wait); end
  endtask

  task automatic test_idle_strobes();
    cu_loadA = 1'b1; cu_pushA = 1'b1; cu_end = 1'b1; outbus = 8'hAA;
    @(negedge clk);
    n_tests++;
    if (inbus !== 8'h00) begin n_fail++; $display("FAIL idle_inbus: got %h want 00", inbus); end
    cyc(); cyc();
    cu_loadA = 1'b0; cu_pushA = 1'b0; cu_end = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_end_ignored: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    cyc();
  endtask

  task automatic test_reset_run();
    req_op = 2'b10; req_a = 8'h00; req_q = 8'h5C; req_m = 8'h03; req_valid = 1'b1;
    cyc();
    req_valid = 1'b0; cyc();
    cu_idle = 1'b0; cyc();
    cu_loadQ = 1'b1;
    @(negedge clk);
    n_tests++;
    if (inbus !== 8'h5C) begin n_fail++; $display("FAIL rstrun_inbus: got %h want 5c", inbus); end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, cu_begin, cu_op_code, inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL rstrun_outputs: rdy=%b beg=%b op=%b inbus=%h v=%b hi=%h lo=%h err=%b want all 0",
               req_ready, cu_begin, cu_op_code, inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err);
    end
    cu_loadQ = 1'b0;
    cyc();
    reset = 1'b1; cu_idle = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstrun_idle: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] a, q, m;
    for (int it = 0; it < 24; it++) begin
      op = 2'($urandom_range(0, 3));
      a = W'($urandom); q = W'($urandom); m = W'($urandom);
      if (op == 2'b11) begin m = W'($urandom_range(1, 255)); a = W'(a % m); end
      run_txn(op, a, q, m, $urandom_range(0, 3));
      check_result($sformatf("rand%0d", it), op, a, q, m);
      if (op != 2'b11 || m != 0) begin
        for (int i = 0; i < obs_nload; i++) begin
          n_tests++;
          if (obs_inbus[i] !== exp_inbus[i]) begin
            n_fail++; $display("FAIL rand%0d_inbus%0d: got %h want %h", it, i, obs_inbus[i], exp_inbus[i]);
          end
        end
      end
    end
  endtask

`ifdef ALU_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    req_op = 2'b10; req_a = 8'h00; req_q = 8'h03; req_m = 8'h05; req_valid = 1'b1;
    @(negedge clk);
    cyc();
    req_valid = 1'b0;
    k = 1;
    while (k < 100) begin
      cu_idle  = (k < 2);
      cu_pushA = (k == 3);
      outbus   = (k == 3 || k == 4) ? 8'h5A : 8'h00;
      @(negedge clk);
      if (rsp_valid) break;
      cyc();
      k++;
    end
    cu_pushA = 1'b0;
    n_tests++;
    if (k != 18) begin n_fail++; $display("FAIL tmo_cycle: rsp_valid at cycle %0d want 18", k); end
    n_tests++;
    if ({rsp_err, rsp_hi, rsp_lo} !== {1'b1, 8'h5A, 8'h00}) begin
      n_fail++; $display("FAIL tmo_result: err=%b hi=%h lo=%h want 1 5a 00", rsp_err, rsp_hi, rsp_lo);
    end
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL tmo_ready_low: got %b want 0", req_ready); end
    cu_idle = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready_high: got %b want 1", req_ready); end
    cyc();
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_op = '0; req_a = '0; req_q = '0; req_m = '0;
    cu_loadA = 1'b0; cu_loadQ = 1'b0; cu_loadM = 1'b0;
    cu_pushA = 1'b0; cu_pushQ = 1'b0; outbus = '0;
    cu_end = 1'b0; cu_idle = 1'b1; rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_div0();
    test_backpressure();
    test_back_to_back();
    test_idle_strobes();
    test_reset_run();
    test_random();
`ifdef ALU_HOST_TIMEOUT_EN
    test_timeout();
`endif
    n_tests++;
    if (both_seen !== 1'b0) begin n_fail++; $display("FAIL ready_valid_overlap: got 1 want 0"); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
